booth_serial_multiplier: RTL and testbench

BOOTH_SERIAL_MULTIPLIER -- requirements
Module: booth_serial_multiplier

---
 rtl/booth_serial_multiplier.sv | 224 ++++++++++++++++++++++
 tb/tb_booth_serial_multiplier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_serial_multiplier.sv
// Radix-2 Booth sequential signed multiplier with a UART-style serial readout.
// One Booth step per cycle for WIDTH cycles, then the 2*WIDTH-bit product is
// framed as start bit, product LSB first, stop bit, each bit CLKS_PER_BIT cycles.
module booth_serial_multiplier #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 tx
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BIT_W = $clog2(2*WIDTH + 2);
    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(2*WIDTH + 1);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH:0]       acc_r;
    logic [WIDTH:0]       m_r;
    logic [WIDTH-1:0]     q_r;
    logic                 q_minus_r;
    logic [CNT_W-1:0]     step_r;
    logic [BIT_W-1:0]     bit_idx_r;
    logic [CYC_W-1:0]     cyc_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       acc_shift_s;
    logic [WIDTH-1:0]     q_shift_s;
    logic                 last_step_s;
    logic                 last_slot_s;
    logic                 last_bit_s;
    logic                 tx_nxt_s;
    logic                 busy_nxt_s;
    logic                 done_nxt_s;

    // Frame bit at position idx: 0 is the start bit, LAST_BIT the stop bit,
    // everything in between is product bit idx-1.
    function automatic logic frame_bit(input logic [BIT_W-1:0] idx,
                                       input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] sh;
        logic               bit_v;
        sh = p >> (idx - BIT_W'(1));
        if (idx == BIT_W'(0)) begin
            bit_v = 1'b0;
        end else if (idx == LAST_BIT) begin
            bit_v = 1'b1;
        end else begin
            bit_v = sh[0];
        end
        return bit_v;
    endfunction

    assign last_step_s = (step_r == LAST_STEP);
    assign last_slot_s = (cyc_r == LAST_CYC);
    assign last_bit_s  = (bit_idx_r == LAST_BIT);

    // Booth add/subtract on {Q[0], q_minus}, then arithmetic right shift of {acc,Q}.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q_minus_r})
            2'b10:   sum_s = acc_r - m_r;
            2'b01:   sum_s = acc_r + m_r;
            default: sum_s = acc_r;
        endcase
        acc_shift_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_shift_s   = {sum_s[0], q_r[WIDTH-1:1]};
    end

    // State register; reset wins over any pending start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_step_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            SEND: begin
                if (last_slot_s && last_bit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the start bit goes out together with done.
    always_comb begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = (state_nxt_s != IDLE);
        done_nxt_s = 1'b0;
        case (state_r)
            CALC: begin
                if (last_step_s) begin
                    tx_nxt_s   = 1'b0;
                    done_nxt_s = 1'b1;
                end else begin
                    tx_nxt_s   = 1'b1;
                    done_nxt_s = 1'b0;
                end
            end
            SEND: begin
                if (!last_slot_s) begin
                    tx_nxt_s = tx_r;
                end else if (last_bit_s) begin
                    tx_nxt_s = 1'b1;
                end else begin
                    tx_nxt_s = frame_bit(bit_idx_r + BIT_W'(1), product_r);
                end
            end
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // Output registers so tx, busy and done never see a combinational input path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand capture, Booth iteration, product latch and serial bit timing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r     <= {(WIDTH+1){1'b0}};
            m_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            q_minus_r <= 1'b0;
            step_r    <= {CNT_W{1'b0}};
            bit_idx_r <= {BIT_W{1'b0}};
            cyc_r     <= {CYC_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r     <= {(WIDTH+1){1'b0}};
                        m_r       <= {multiplicand[WIDTH-1], multiplicand};
                        q_r       <= multiplier;
                        q_minus_r <= 1'b0;
                        step_r    <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    acc_r     <= acc_shift_s;
                    q_r       <= q_shift_s;
                    q_minus_r <= q_r[0];
                    step_r    <= step_r + CNT_W'(1);
                    if (last_step_s) begin
                        product_r <= {acc_shift_s[WIDTH-1:0], q_shift_s};
                        bit_idx_r <= {BIT_W{1'b0}};
                        cyc_r     <= {CYC_W{1'b0}};
                    end
                end
                SEND: begin
                    if (last_slot_s) begin
                        cyc_r <= {CYC_W{1'b0}};
                        if (last_bit_s) begin
                            bit_idx_r <= {BIT_W{1'b0}};
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                        end
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_serial_multiplier.sv
// Self-checking bench: a WIDTH=4/CLKS_PER_BIT=1 instance driven from a vector
// table, an exhaustive sweep and corner sequences, plus a WIDTH=8/CLKS_PER_BIT=3
// instance for the slow-frame case. Products are checked through a scoreboard.
module tb_booth_serial_multiplier;

    logic        clk;
    logic        rst;
    logic        start4;
    logic [3:0]  mult4;
    logic [3:0]  mcand4;
    logic        busy4;
    logic        done4;
    logic [7:0]  prod4;
    logic        tx4;
    logic        start8;
    logic [7:0]  mult8;
    logic [7:0]  mcand8;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;
    logic        tx8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] q;
        logic [3:0] m;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[8];

    booth_serial_multiplier #(.WIDTH(4), .CLKS_PER_BIT(1)) dut4 (
        .CLK(clk), .RST(rst), .start(start4), .multiplier(mult4),
        .multiplicand(mcand4), .busy(busy4), .done(done4),
        .product(prod4), .tx(tx4)
    );

    booth_serial_multiplier #(.WIDTH(8), .CLKS_PER_BIT(3)) dut8 (
        .CLK(clk), .RST(rst), .start(start8), .multiplier(mult8),
        .multiplicand(mcand8), .busy(busy8), .done(done8),
        .product(prod8), .tx(tx8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse of the 4-bit instance consumes one expected product.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: product %0h with empty scoreboard", prod4);
            end else begin
                check("product", {56'd0, prod4}, {56'd0, sb.pop_front()});
            end
        end
    end

    // One operation on the 4-bit instance; tracks latency, busy length and the tx frame.
    task automatic run_op4(input logic [3:0] q, input logic [3:0] m,
                           input logic [7:0] exp, input bit full);
        int busy_cnt;
        int done_at;
        int pos;
        logic [9:0] rx;
        logic [9:0] exp_frame;
        exp_frame = {1'b1, exp, 1'b0};
        rx        = 10'h3FF;
        busy_cnt  = 0;
        done_at   = -1;
        pos       = -1;
        @(negedge clk);
        mult4  = q;
        mcand4 = m;
        start4 = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start4 = 1'b0;
        mult4  = ~q;
        mcand4 = ~m;
        for (int c = 0; c < 200; c++) begin
            if (busy4 !== 1'b1) break;
            busy_cnt++;
            if (done4 === 1'b1) begin
                done_at = c;
                pos     = 0;
            end
            if (pos >= 0 && pos < 10) begin
                rx[pos] = tx4;
                pos++;
            end
            @(negedge clk);
        end
        if (full) begin
            check("done_latency", 64'(done_at), 64'd4);
            check("busy_len", 64'(busy_cnt), 64'd14);
            check("tx_frame", {54'd0, rx}, {54'd0, exp_frame});
            check("tx_idle", {63'd0, tx4}, 64'd1);
        end
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int done_at;
        int pos;
        int bad;
        logic signed [3:0] qa;
        logic signed [3:0] mb;
        logic signed [7:0] pr;
        logic [17:0] frame8;

        vecs[0] = '{4'h3, 4'hE, 8'hFA};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h7, 4'h8, 8'hC8};
        vecs[3] = '{4'h0, 4'hB, 8'h00};
        vecs[4] = '{4'hF, 4'hF, 8'h01};
        vecs[5] = '{4'h8, 4'h7, 8'hC8};
        vecs[6] = '{4'h5, 4'h3, 8'h0F};
        vecs[7] = '{4'hD, 4'h6, 8'hEE};

        rst    = 1'b1;
        start4 = 1'b0;
        mult4  = 4'h0;
        mcand4 = 4'h0;
        start8 = 1'b0;
        mult8  = 8'h00;
        mcand8 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state4", {52'd0, tx4, busy4, done4, prod4}, {52'd0, 3'b100, 8'h00});
        check("reset_state8", {45'd0, tx8, busy8, done8, prod8}, {45'd0, 3'b100, 16'h0000});
        rst = 1'b0;

        // Directed vectors with full timing/frame checks.
        for (int i = 0; i < 8; i++) begin
            run_op4(vecs[i].q, vecs[i].m, vecs[i].p, 1'b1);
        end

        // start held high with operands changed mid-CALC.
        @(negedge clk);
        mult4  = 4'h3;
        mcand4 = 4'h5;
        start4 = 1'b1;
        sb.push_back(8'h0F);
        @(negedge clk);
        mult4  = 4'h8;
        mcand4 = 4'h8;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (busy4 !== 1'b1) break;
            busy_cnt++;
            if (done4 === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("held_done_count", 64'(done_cnt), 64'd1);
        check("held_busy_len", 64'(busy_cnt), 64'd14);
        sb.push_back(8'h40);
        @(negedge clk);
        start4 = 1'b0;
        check("restart_first_idle", {63'd0, busy4}, 64'd1);
        for (int c = 0; c < 100; c++) begin
            if (busy4 !== 1'b1) break;
            @(negedge clk);
        end

        // Reset during the 5th SEND bit, with start asserted during reset.
        @(negedge clk);
        mult4  = 4'h3;
        mcand4 = 4'hE;
        start4 = 1'b1;
        sb.push_back(8'hFA);
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done4 === 1'b1) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        rst    = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        check("abort_state", {52'd0, tx4, busy4, done4, prod4}, {52'd0, 3'b100, 8'h00});
        @(negedge clk);
        rst    = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
        check("start_ignored_in_rst", {63'd0, busy4}, 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done4 === 1'b1 || tx4 !== 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("quiet_after_abort", 64'(done_cnt), 64'd0);
        run_op4(4'h3, 4'hE, 8'hFA, 1'b1);

        // Exhaustive operand sweep against the signed reference product.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                qa = 4'(a);
                mb = 4'(b);
                pr = qa * mb;
                run_op4(qa, mb, pr, 1'b0);
            end
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Slow frame on the 8-bit instance: Q=-128, M=127.
        frame8 = {1'b1, 16'hC080, 1'b0};
        @(negedge clk);
        mult8  = 8'h80;
        mcand8 = 8'h7F;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        mult8  = 8'h00;
        mcand8 = 8'h00;
        busy_cnt = 0;
        done_at  = -1;
        pos      = -1;
        bad      = 0;
        for (int c = 0; c < 500; c++) begin
            if (busy8 !== 1'b1) break;
            busy_cnt++;
            if (done8 === 1'b1) begin
                done_at = c;
                pos     = 0;
            end
            if (pos >= 0 && pos < 54) begin
                if (tx8 !== frame8[pos / 3]) bad++;
                pos++;
            end
            @(negedge clk);
        end
        check("w8_done_latency", 64'(done_at), 64'd8);
        check("w8_busy_len", 64'(busy_cnt), 64'd62);
        check("w8_frame_cycles", 64'(pos), 64'd54);
        check("w8_frame_bad_bits", 64'(bad), 64'd0);
        check("w8_product", {48'd0, prod8}, {48'd0, 16'hC080});
        check("w8_tx_idle", {63'd0, tx8}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
